// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Multi-cycle control sequencer for the picoMIPS core. Each instruction is
//   latched in FETCH and decoded in EXEC, which drives the PC increment /
//   relative-branch strobes and the datapath write/select controls. IN stalls
//   on a button press/release handshake. HALT is absorbing until reset.
//
// Ports
//   clk          in   1      system clock, rising edge
//   reset        in   1      synchronous, active-high reset
//   instr        in   Isize  program memory word at current PC
//   zflag        in   1      registered ALU zero flag, valid in EXEC
//   btn          in   1      synchronised, debounced button (1 = pressed)
//   PCincr       out  1      PC += 1 this edge
//   PCrelbranch  out  1      PC += Branchaddr this edge
//   Branchaddr   out  Psize  two's-complement relative offset from ir
//   reg_we       out  1      register-file write enable
//   imm_sel      out  1      ALU operand B from immediate (1) / register (0)
//   in_sel       out  1      write-back from switches (1) / ALU (0)
//   alu_op       out  2      00 pass, 01 add, 10 mult
//   halted       out  1      high in HALT state
//   icount       out  Csize  retired instructions, saturating
//   state_dbg    out  3      current FSM state encoding, for observation
//
// Handshake: IN has no valid/ready pair; the button level is the only
// qualifier. In WAITP a high btn is the press (write-back happens in that
// same cycle); in WAITR a low btn is the release (PC advances in that cycle).
module pc_sequencer #(
    parameter int Psize = 5,
    parameter int Isize = 16,
    parameter int Csize = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [Isize-1:0] instr,
    input  logic             zflag,
    input  logic             btn,
    output logic             PCincr,
    output logic             PCrelbranch,
    output logic [Psize-1:0] Branchaddr,
    output logic             reg_we,
    output logic             imm_sel,
    output logic             in_sel,
    output logic [1:0]       alu_op,
    output logic             halted,
    output logic [Csize-1:0] icount,
    output logic [2:0]       state_dbg
);

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_EXEC  = 3'd1,
        S_WAITP = 3'd2,
        S_WAITR = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_ADDI = 3'b010;
    localparam logic [2:0] OP_MULI = 3'b011;
    localparam logic [2:0] OP_BEQ  = 3'b100;
    localparam logic [2:0] OP_BNE  = 3'b101;
    localparam logic [2:0] OP_IN   = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    state_t           state;
    state_t           state_next;

    // Only the opcode and offset fields of the instruction register are ever
    // used, so only those are held.
    logic [2:0]       ir_op;
    logic [Psize-1:0] ir_off;

    // Middle instruction bits carry no meaning for the sequencer.
    logic             unused_instr_bits;
    assign unused_instr_bits = ^instr[Isize-4:Psize];

    assign Branchaddr = ir_off;
    assign state_dbg  = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_FETCH;
            ir_op  <= '0;
            ir_off <= '0;
            icount <= '0;
        end else begin
            state <= state_next;
            if (state == S_FETCH) begin
                ir_op  <= instr[Isize-1 -: 3];
                ir_off <= instr[Psize-1:0];
            end
            // An instruction retires on the cycle the PC moves.
            if ((PCincr || PCrelbranch) && (icount != {Csize{1'b1}})) begin
                icount <= icount + Csize'(1);
            end
        end
    end

    always_comb begin
        state_next  = S_FETCH;
        PCincr      = 1'b0;
        PCrelbranch = 1'b0;
        reg_we      = 1'b0;
        imm_sel     = 1'b0;
        in_sel      = 1'b0;
        alu_op      = 2'b00;
        halted      = 1'b0;

        case (state)
            S_FETCH: state_next = S_EXEC;

            S_EXEC: begin
                state_next = S_FETCH;
                case (ir_op)
                    OP_NOP: PCincr = 1'b1;
                    OP_ADD: begin
                        reg_we = 1'b1;
                        alu_op = 2'b01;
                        PCincr = 1'b1;
                    end
                    OP_ADDI: begin
                        reg_we  = 1'b1;
                        imm_sel = 1'b1;
                        alu_op  = 2'b01;
                        PCincr  = 1'b1;
                    end
                    OP_MULI: begin
                        reg_we  = 1'b1;
                        imm_sel = 1'b1;
                        alu_op  = 2'b10;
                        PCincr  = 1'b1;
                    end
                    OP_BEQ: begin
                        PCrelbranch = zflag;
                        PCincr      = ~zflag;
                    end
                    OP_BNE: begin
                        PCrelbranch = ~zflag;
                        PCincr      = zflag;
                    end
                    OP_IN:   state_next = S_WAITP;
                    OP_HALT: state_next = S_HALT;
                    default: state_next = S_FETCH;
                endcase
            end

            S_WAITP: begin
                if (btn) begin
                    reg_we     = 1'b1;
                    in_sel     = 1'b1;
                    state_next = S_WAITR;
                end else begin
                    state_next = S_WAITP;
                end
            end

            S_WAITR: begin
                if (!btn) begin
                    PCincr     = 1'b1;
                    state_next = S_FETCH;
                end else begin
                    state_next = S_WAITR;
                end
            end

            S_HALT: begin
                halted     = 1'b1;
                state_next = S_HALT;
            end

            default: state_next = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] instr;
    logic        zflag;
    logic        btn;

    logic        PCincr, PCrelbranch, reg_we, imm_sel, in_sel, halted;
    logic [4:0]  Branchaddr;
    logic [1:0]  alu_op;
    logic [7:0]  icount;
    logic [2:0]  state_dbg;

    logic        PCincr2, PCrelbranch2, reg_we2, imm_sel2, in_sel2, halted2;
    logic [4:0]  Branchaddr2;
    logic [1:0]  alu_op2;
    logic [1:0]  icount2;
    logic [2:0]  state_dbg2;

    int tests  = 0;
    int failed = 0;
    int exp_cnt = 0;

    pc_sequencer #(.Psize(5), .Isize(16), .Csize(8)) dut (
        .clk(clk), .reset(reset), .instr(instr), .zflag(zflag), .btn(btn),
        .PCincr(PCincr), .PCrelbranch(PCrelbranch), .Branchaddr(Branchaddr),
        .reg_we(reg_we), .imm_sel(imm_sel), .in_sel(in_sel), .alu_op(alu_op),
        .halted(halted), .icount(icount), .state_dbg(state_dbg)
    );

    // Narrow counter instance for the saturation check; shares all inputs.
    pc_sequencer #(.Psize(5), .Isize(16), .Csize(2)) dut2 (
        .clk(clk), .reset(reset), .instr(instr), .zflag(zflag), .btn(btn),
        .PCincr(PCincr2), .PCrelbranch(PCrelbranch2), .Branchaddr(Branchaddr2),
        .reg_we(reg_we2), .imm_sel(imm_sel2), .in_sel(in_sel2), .alu_op(alu_op2),
        .halted(halted2), .icount(icount2), .state_dbg(state_dbg2)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    // Control bundle: {PCincr, PCrelbranch, reg_we, imm_sel, in_sel, alu_op[1:0], halted}
    function automatic logic [7:0] ctl();
        return {PCincr, PCrelbranch, reg_we, imm_sel, in_sel, alu_op, halted};
    endfunction

    function automatic logic [15:0] mk(input logic [2:0] op, input logic [4:0] off);
        return {op, 8'hA5, off};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one clock; leave us 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        repeat (cycles) tick();
        reset = 1'b0;
        exp_cnt = 0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [2:0] op;
        logic [4:0] off;
        logic       z;
        logic [7:0] exp_ctl;
    } vec_t;

    vec_t vecs[10];

    initial begin
        reset = 1'b0;
        instr = '0;
        zflag = 1'b0;
        btn   = 1'b0;

        vecs[0] = '{3'b000, 5'd3,     1'b0, 8'b1000_0000}; // NOP
        vecs[1] = '{3'b010, 5'd7,     1'b0, 8'b1011_0010}; // ADDI
        vecs[2] = '{3'b011, 5'd9,     1'b1, 8'b1011_0100}; // MULI
        vecs[3] = '{3'b001, 5'd1,     1'b1, 8'b1010_0010}; // ADD
        vecs[4] = '{3'b100, 5'b11110, 1'b1, 8'b0100_0000}; // BEQ taken, -2
        vecs[5] = '{3'b100, 5'b11110, 1'b0, 8'b1000_0000}; // BEQ not taken
        vecs[6] = '{3'b101, 5'b00001, 1'b0, 8'b0100_0000}; // BNE taken
        vecs[7] = '{3'b101, 5'b00001, 1'b1, 8'b1000_0000}; // BNE not taken
        vecs[8] = '{3'b100, 5'b00000, 1'b1, 8'b0100_0000}; // BEQ self-loop
        vecs[9] = '{3'b000, 5'd31,    1'b1, 8'b1000_0000}; // NOP, zflag ignored

        // ---- reset state ----
        do_reset(2);
        #1;
        check("reset_ctl", ctl(), 8'h00);
        check("reset_icount", icount, 0);

        // ---- table: FETCH then EXEC per instruction ----
        for (int i = 0; i < 10; i++) begin
            instr = mk(vecs[i].op, vecs[i].off);
            zflag = vecs[i].z;
            #1;
            check($sformatf("vec%0d_fetch_ctl", i), ctl(), 8'h00);
            check($sformatf("vec%0d_icount", i), icount, exp_cnt);
            tick();
            // Change memory under the latched ir: decode must not follow it.
            instr = 16'hFFFF;
            #1;
            check($sformatf("vec%0d_exec_ctl", i), ctl(), vecs[i].exp_ctl);
            check($sformatf("vec%0d_branchaddr", i), Branchaddr, vecs[i].off);
            if (vecs[i].exp_ctl[7] || vecs[i].exp_ctl[6]) exp_cnt++;
            tick();
        end
        check("table_icount", icount, exp_cnt);

        // ---- IN handshake: low 10, high 4, then low ----
        instr = mk(3'b110, 5'd0);
        zflag = 1'b0;
        btn   = 1'b0;
        tick();                                  // FETCH -> EXEC
        check("in_exec_ctl", ctl(), 8'h00);
        tick();                                  // EXEC -> WAITP
        for (int c = 0; c < 10; c++) begin
            check($sformatf("in_waitp_low%0d", c), ctl(), 8'h00);
            tick();
        end
        btn = 1'b1;
        #1;
        check("in_press_ctl", ctl(), 8'b0010_1000);
        tick();
        for (int c = 0; c < 3; c++) begin
            check($sformatf("in_waitr_high%0d", c), ctl(), 8'h00);
            tick();
        end
        check("in_stall_icount", icount, exp_cnt);
        btn = 1'b0;
        #1;
        check("in_release_ctl", ctl(), 8'b1000_0000);
        exp_cnt++;
        tick();
        check("in_after_fetch_ctl", ctl(), 8'h00);
        check("in_icount", icount, exp_cnt);

        // ---- reset held 3 cycles mid-WAITR ----
        instr = mk(3'b110, 5'd0);
        tick();                                  // -> EXEC
        tick();                                  // -> WAITP
        btn = 1'b1;
        tick();                                  // press -> WAITR
        check("rst_pre_waitr_ctl", ctl(), 8'h00);
        instr = mk(3'b000, 5'd0);
        do_reset(3);
        btn = 1'b0;
        #1;
        check("rst_waitr_ctl", ctl(), 8'h00);
        check("rst_waitr_icount", icount, 0);
        tick();                                  // FETCH -> EXEC with NOP
        check("rst_waitr_next_nop", ctl(), 8'b1000_0000);
        tick();

        // ---- HALT is absorbing ----
        exp_cnt = 1;
        instr = mk(3'b111, 5'd4);
        tick();                                  // -> EXEC
        check("halt_exec_ctl", ctl(), 8'h00);
        tick();                                  // -> HALT
        for (int c = 0; c < 20; c++) begin
            btn   = 1'($urandom_range(0, 1));
            zflag = 1'($urandom_range(0, 1));
            instr = 16'($urandom_range(0, 65535));
            #1;
            check($sformatf("halt_ctl%0d", c), ctl(), 8'b0000_0001);
            tick();
        end
        check("halt_icount", icount, exp_cnt);
        do_reset(1);
        btn = 1'b0;
        zflag = 1'b0;
        #1;
        check("halt_reset_ctl", ctl(), 8'h00);
        check("halt_reset_icount", icount, 0);

        // ---- Csize=2 saturation with 5 NOPs ----
        instr = mk(3'b000, 5'd0);
        for (int n = 0; n < 5; n++) begin
            tick();                              // -> EXEC
            tick();                              // retire -> FETCH
            check($sformatf("sat_icount%0d", n), icount2, (n < 3) ? n + 1 : 3);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
